// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lc3_mem_pkg
// Shared types and constants for the LC-3 memory-access sequencer.
//   mem_state_t  : sequencer states (IDLE, ACCESS, HOLD, DONE)
//   MEM_ADDR_W   : default SRAM address width
//   MEM_DATA_W   : default SRAM word width
//   cnt_width()  : wait-state counter width, never narrower than one bit
// -----------------------------------------------------------------------------
package lc3_mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD, DONE} mem_state_t;

  // $clog2(1) is 0, so zero wait states still need a one-bit counter.
  function automatic int cnt_width(input int waits);
    return (waits < 1) ? 1 : $clog2(waits + 1);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Bundles the request side (control FSM / MAR / MDR) and the SRAM side of the
// memory-access sequencer.
//   Request side : Req, RW, Addr, Wdata -> ; <- Rdata, Ld_MDR, Done, Ready
//   SRAM side    : <- Mem_Addr, Mem_Data_Out, Mem_Data_OE, Mem_CE_n,
//                   Mem_OE_n, Mem_WE_n ; Mem_Data_In ->
//   slave  modport : the sequencer
//   master modport : the requester plus the SRAM model / pad logic
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) ();

  logic              Req;
  logic              RW;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Wdata;
  logic [DATA_W-1:0] Rdata;
  logic              Ld_MDR;
  logic              Done;
  logic              Ready;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Data_Out;
  logic              Mem_Data_OE;
  logic [DATA_W-1:0] Mem_Data_In;
  logic              Mem_CE_n;
  logic              Mem_OE_n;
  logic              Mem_WE_n;

  modport slave (
    input  Req, RW, Addr, Wdata, Mem_Data_In,
    output Rdata, Ld_MDR, Done, Ready,
    output Mem_Addr, Mem_Data_Out, Mem_Data_OE, Mem_CE_n, Mem_OE_n, Mem_WE_n
  );

  modport master (
    output Req, RW, Addr, Wdata, Mem_Data_In,
    input  Rdata, Ld_MDR, Done, Ready,
    input  Mem_Addr, Mem_Data_Out, Mem_Data_OE, Mem_CE_n, Mem_OE_n, Mem_WE_n
  );

endinterface

// File: rtl/mem_access_ctrl_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
// Wait-state down-counter for the memory-access sequencer.
//   Clk      : rising-edge clock
//   Reset    : asynchronous active-low reset (count := 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement; saturates at zero
//   zero     : count is zero
// -----------------------------------------------------------------------------
module mem_wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Sequences one-word reads and writes between the LC-3 MAR/MDR and an external
// asynchronous SRAM, holding the strobes for WAIT_CYCLES extra cycles.
//   Clk   : rising-edge clock
//   Reset : asynchronous active-low reset, effective immediately
//   bus   : mem_access_ctrl_if.slave
//           Req/RW/Addr/Wdata sampled only when idle; Rdata held until the
//           next read; Ld_MDR/Done one-cycle pulses; Ready high when idle;
//           registered SRAM address, write data, output enable and
//           active-low CE/OE/WE strobes; Mem_Data_In is the SRAM read bus.
// Read : IDLE -> ACCESS x (WAIT_CYCLES+1) -> DONE -> IDLE
// Write: IDLE -> ACCESS x (WAIT_CYCLES+1) -> HOLD -> DONE -> IDLE
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  mem_access_ctrl_if.slave bus
);

  localparam int               CNT_W   = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  mem_state_t        state, state_n;
  logic              rw_q, rw_n;
  logic              latch, capture;
  logic              cnt_load, cnt_dec, cnt_zero;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              ce_n_q, oe_n_q, we_n_q, data_oe_q;
  logic              done_q, ld_q, ready_q;

  mem_wait_counter #(
    .WIDTH(CNT_W)
  ) u_wait (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (WAIT_LD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    latch    = 1'b0;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Req) begin
          state_n  = ACCESS;
          latch    = 1'b1;
          cnt_load = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          state_n = rw_q ? HOLD : DONE;
          capture = !rw_q;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLD:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Direction of the access the next state belongs to; a new request's RW
  // must steer the strobes in its very first ACCESS cycle.
  assign rw_n = latch ? bus.RW : rw_q;

  // Outputs are registered from the next state so they change exactly with
  // the state register and never glitch on state decode.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ld_q      <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      ce_n_q    <= !((state_n == ACCESS) || (state_n == HOLD));
      oe_n_q    <= !((state_n == ACCESS) && !rw_n);
      we_n_q    <= !((state_n == ACCESS) && rw_n);
      data_oe_q <= ((state_n == ACCESS) || (state_n == HOLD)) && rw_n;
      done_q    <= (state_n == DONE);
      ld_q      <= (state_n == DONE) && !rw_n;
      ready_q   <= (state_n == IDLE);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (latch) begin
        rw_q    <= bus.RW;
        addr_q  <= bus.Addr;
        wdata_q <= bus.Wdata;
      end
      if (capture) begin
        rdata_q <= bus.Mem_Data_In;
      end
    end
  end

  assign bus.Rdata        = rdata_q;
  assign bus.Ld_MDR       = ld_q;
  assign bus.Done         = done_q;
  assign bus.Ready        = ready_q;
  assign bus.Mem_Addr     = addr_q;
  assign bus.Mem_Data_Out = wdata_q;
  assign bus.Mem_Data_OE  = data_oe_q;
  assign bus.Mem_CE_n     = ce_n_q;
  assign bus.Mem_OE_n     = oe_n_q;
  assign bus.Mem_WE_n     = we_n_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Two sequencers side by side: channel 0 with two wait states, channel 1 with
// none. Each has its own SRAM model. A transaction-level model predicts every
// output from the cycle offset inside the current access.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;
  import lc3_mem_pkg::*;

  localparam int W_A = 2;
  localparam int W_B = 0;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
  mem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W_A)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(bus_a)
  );
  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W_B)) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(bus_b)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // SRAM models: readable while CE_n and OE_n are low, written on edges
  // where CE_n and WE_n are low. Preloaded on the first clock edge.
  logic [15:0] sram_a [65536];
  logic [15:0] sram_b [65536];
  logic        init_done = 1'b0;

  assign bus_a.Mem_Data_In = (!bus_a.Mem_CE_n && !bus_a.Mem_OE_n) ? sram_a[bus_a.Mem_Addr] : 16'h0000;
  assign bus_b.Mem_Data_In = (!bus_b.Mem_CE_n && !bus_b.Mem_OE_n) ? sram_b[bus_b.Mem_Addr] : 16'h0000;

  always @(posedge Clk) begin
    if (!init_done) begin
      sram_a[16'h3000] <= 16'hBEEF;
      sram_a[16'h0000] <= 16'hA000;
      sram_a[16'h0001] <= 16'hA001;
      sram_a[16'h0002] <= 16'hA002;
      sram_b[16'h0010] <= 16'h5A5A;
      init_done        <= 1'b1;
    end else begin
      if (!bus_a.Mem_CE_n && !bus_a.Mem_WE_n) sram_a[bus_a.Mem_Addr] <= bus_a.Mem_Data_Out;
      if (!bus_b.Mem_CE_n && !bus_b.Mem_WE_n) sram_b[bus_b.Mem_Addr] <= bus_b.Mem_Data_Out;
    end
  end

  // ---------------- transaction-level model ----------------
  // k = cycle number inside an access: 1..W+1 strobing, then HOLD (writes),
  // then the completion cycle; total length W+2 (read) or W+3 (write).
  bit          act    [2] = '{1'b0, 1'b0};
  int          k      [2] = '{0, 0};
  logic        rw_m   [2] = '{1'b0, 1'b0};
  logic [15:0] maddr  [2] = '{16'h0, 16'h0};
  logic [15:0] mdout  [2] = '{16'h0, 16'h0};
  logic [15:0] mrdata [2] = '{16'h0, 16'h0};

  function automatic int wait_of(input int c);
    return (c == 0) ? W_A : W_B;
  endfunction
  function automatic logic req_of(input int c);
    return (c == 0) ? bus_a.Req : bus_b.Req;
  endfunction
  function automatic logic rw_of(input int c);
    return (c == 0) ? bus_a.RW : bus_b.RW;
  endfunction
  function automatic logic [15:0] addr_of(input int c);
    return (c == 0) ? bus_a.Addr : bus_b.Addr;
  endfunction
  function automatic logic [15:0] wdata_of(input int c);
    return (c == 0) ? bus_a.Wdata : bus_b.Wdata;
  endfunction
  function automatic logic [15:0] sram_rd(input int c, input logic [15:0] a);
    return (c == 0) ? sram_a[a] : sram_b[a];
  endfunction
  function automatic int len_of(input int c);
    return wait_of(c) + (rw_m[c] ? 3 : 2);
  endfunction
  function automatic bit e_access(input int c);
    return act[c] && (k[c] <= wait_of(c) + 1);
  endfunction
  function automatic bit e_hold(input int c);
    return act[c] && rw_m[c] && (k[c] == wait_of(c) + 2);
  endfunction
  function automatic bit e_done(input int c);
    return act[c] && (k[c] == len_of(c));
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int c = 0; c < 2; c++) begin
        act[c] <= 1'b0; k[c] <= 0; rw_m[c] <= 1'b0;
        maddr[c] <= 16'h0; mdout[c] <= 16'h0; mrdata[c] <= 16'h0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (!act[c]) begin
          if (req_of(c)) begin
            act[c]   <= 1'b1;
            k[c]     <= 1;
            rw_m[c]  <= rw_of(c);
            maddr[c] <= addr_of(c);
            mdout[c] <= wdata_of(c);
          end
        end else begin
          if (!rw_m[c] && (k[c] == wait_of(c) + 1)) mrdata[c] <= sram_rd(c, maddr[c]);
          if (k[c] == len_of(c)) act[c] <= 1'b0;
          else                   k[c]   <= k[c] + 1;
        end
      end
    end
  end

  // ---------------- check helpers ----------------
  task automatic chk_b(input string nm, input logic act_v, input logic exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", nm, act_v, exp_v, $time);
    end
  endtask
  task automatic chk_h(input string nm, input logic [15:0] act_v, input logic [15:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act_v, exp_v, $time);
    end
  endtask
  task automatic chk_i(input string nm, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act_v, exp_v, $time);
    end
  endtask

  task automatic cmp_chan(input int c, input logic [15:0] rdata, input logic [15:0] maddr_o,
                          input logic [15:0] mdout_o, input logic ld, input logic done,
                          input logic ready, input logic doe, input logic ce_n,
                          input logic oe_n, input logic we_n);
    string p;
    p = $sformatf("ch%0d_", c);
    chk_h({p, "rdata"},    rdata,   mrdata[c]);
    chk_h({p, "mem_addr"}, maddr_o, maddr[c]);
    chk_h({p, "mem_dout"}, mdout_o, mdout[c]);
    chk_b({p, "ready"},    ready,   !act[c]);
    chk_b({p, "done"},     done,    e_done(c));
    chk_b({p, "ld_mdr"},   ld,      e_done(c) && !rw_m[c]);
    chk_b({p, "ce_n"},     ce_n,    !(e_access(c) || e_hold(c)));
    chk_b({p, "oe_n"},     oe_n,    !(e_access(c) && !rw_m[c]));
    chk_b({p, "we_n"},     we_n,    !(e_access(c) && rw_m[c]));
    chk_b({p, "data_oe"},  doe,     (e_access(c) || e_hold(c)) && rw_m[c]);
    chk_b({p, "oe_we_excl"}, !oe_n && !we_n, 1'b0);
  endtask

  // ---------------- per-channel stimulus / observation ----------------
  task automatic drive(input int c, input logic req, input logic rw,
                       input logic [15:0] a, input logic [15:0] d);
    if (c == 0) begin
      bus_a.Req = req; bus_a.RW = rw; bus_a.Addr = a; bus_a.Wdata = d;
    end else begin
      bus_b.Req = req; bus_b.RW = rw; bus_b.Addr = a; bus_b.Wdata = d;
    end
  endtask

  function automatic logic o_ready(input int c); return (c == 0) ? bus_a.Ready    : bus_b.Ready;    endfunction
  function automatic logic o_done (input int c); return (c == 0) ? bus_a.Done     : bus_b.Done;     endfunction
  function automatic logic o_ld   (input int c); return (c == 0) ? bus_a.Ld_MDR   : bus_b.Ld_MDR;   endfunction
  function automatic logic o_oe_n (input int c); return (c == 0) ? bus_a.Mem_OE_n : bus_b.Mem_OE_n; endfunction
  function automatic logic o_we_n (input int c); return (c == 0) ? bus_a.Mem_WE_n : bus_b.Mem_WE_n; endfunction
  function automatic logic o_ce_n (input int c); return (c == 0) ? bus_a.Mem_CE_n : bus_b.Mem_CE_n; endfunction
  function automatic logic o_doe  (input int c); return (c == 0) ? bus_a.Mem_Data_OE : bus_b.Mem_Data_OE; endfunction
  function automatic logic [15:0] o_rdata(input int c); return (c == 0) ? bus_a.Rdata : bus_b.Rdata; endfunction
  function automatic logic [15:0] o_maddr(input int c); return (c == 0) ? bus_a.Mem_Addr : bus_b.Mem_Addr; endfunction

  task automatic wait_ready(input int c);
    for (int i = 0; i < 20 && !o_ready(c); i++) @(negedge Clk);
    chk_b($sformatf("ch%0d_wait_ready", c), o_ready(c), 1'b1);
  endtask

  // Cycle 0 is the idle cycle in which Req is presented; latency is the
  // cycle number in which Done is first seen.
  task automatic run_access(input int c, input logic rw, input logic [15:0] a,
                            input logic [15:0] d, input int exp_lat,
                            input int exp_strobe, input string nm);
    int lat, oe_lo, we_lo, ld_seen;
    bit seen;
    lat = 0; oe_lo = 0; we_lo = 0; ld_seen = 0; seen = 1'b0;
    wait_ready(c);
    drive(c, 1'b1, rw, a, d);
    for (int i = 1; i <= 30 && !seen; i++) begin
      @(negedge Clk);
      if (i == 1) drive(c, 1'b0, rw, a, d);
      if (!o_oe_n(c)) oe_lo++;
      if (!o_we_n(c)) we_lo++;
      if (o_ld(c)) ld_seen++;
      if (rw && (i == exp_lat - 1)) begin
        chk_b({nm, "_hold_we_n"}, o_we_n(c), 1'b1);
        chk_b({nm, "_hold_ce_n"}, o_ce_n(c), 1'b0);
        chk_b({nm, "_hold_doe"},  o_doe(c),  1'b1);
      end
      if (o_done(c)) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk_i({nm, "_latency"}, lat, exp_lat);
    chk_i({nm, "_oe_low_cycles"}, oe_lo, rw ? 0 : exp_strobe);
    chk_i({nm, "_we_low_cycles"}, we_lo, rw ? exp_strobe : 0);
    chk_i({nm, "_ld_mdr_pulses"}, ld_seen, rw ? 0 : 1);
    @(negedge Clk);
    chk_b({nm, "_done_one_cycle"}, o_done(c), 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dcyc [4];
    int nd, rdy, ndone, next_addr;
    bit prev_idle;

    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);

    fork
      forever begin
        @(negedge Clk);
        if (cmp_en) begin
          cmp_chan(0, bus_a.Rdata, bus_a.Mem_Addr, bus_a.Mem_Data_Out, bus_a.Ld_MDR, bus_a.Done,
                   bus_a.Ready, bus_a.Mem_Data_OE, bus_a.Mem_CE_n, bus_a.Mem_OE_n, bus_a.Mem_WE_n);
          cmp_chan(1, bus_b.Rdata, bus_b.Mem_Addr, bus_b.Mem_Data_Out, bus_b.Ld_MDR, bus_b.Done,
                   bus_b.Ready, bus_b.Mem_Data_OE, bus_b.Mem_CE_n, bus_b.Mem_OE_n, bus_b.Mem_WE_n);
        end
      end
    join_none

    // Power-on reset takes effect before any clock edge.
    #3 Reset = 1'b0;
    #1;
    chk_b("por_ready", bus_a.Ready,    1'b1);
    chk_b("por_ce_n",  bus_a.Mem_CE_n, 1'b1);
    chk_h("por_rdata", bus_a.Rdata,    16'h0000);
    repeat (3) @(negedge Clk);
    Reset  = 1'b1;
    cmp_en = 1'b1;
    @(negedge Clk);

    // Read 0x3000 with two wait states.
    run_access(0, 1'b0, 16'h3000, 16'h0000, 4, 3, "rd3000");
    chk_h("rd3000_rdata", bus_a.Rdata, 16'hBEEF);

    // Write 0x1234 to 0x4001.
    run_access(0, 1'b1, 16'h4001, 16'h1234, 5, 3, "wr4001");
    chk_h("wr4001_rdata_kept", bus_a.Rdata, 16'hBEEF);
    chk_h("wr4001_sram", sram_a[16'h4001], 16'h1234);

    // Req toggled with a different address and direction mid-access.
    wait_ready(0);
    drive(0, 1'b1, 1'b0, 16'h3000, 16'h0000);
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      drive(0, (i == 1) || (i == 3), 1'b1, 16'hFFFF, 16'h5555);
      if (bus_a.Done) ndone++;
      if (i <= 4) chk_h("ignore_mem_addr", bus_a.Mem_Addr, 16'h3000);
    end
    chk_i("ignore_done_pulses", ndone, 1);
    chk_h("ignore_rdata", bus_a.Rdata, 16'hBEEF);
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Three back-to-back reads with Req held high.
    wait_ready(0);
    drive(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    nd = 0; rdy = 0; next_addr = 1; prev_idle = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (prev_idle) begin
        if (next_addr < 3) drive(0, 1'b1, 1'b0, 16'(next_addr), 16'h0000);
        else               drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        next_addr++;
      end
      if (bus_a.Done && nd < 4) begin
        dcyc[nd] = i;
        nd++;
      end
      if (bus_a.Ready && nd > 0 && nd < 3) rdy++;
      prev_idle = bus_a.Ready;
    end
    chk_i("b2b_done_count", nd, 3);
    chk_i("b2b_first_done", dcyc[0], 4);
    chk_i("b2b_spacing_1", dcyc[1] - dcyc[0], 5);
    chk_i("b2b_spacing_2", dcyc[2] - dcyc[1], 5);
    chk_i("b2b_ready_between", rdy, 2);
    chk_h("b2b_rdata", bus_a.Rdata, 16'hA002);

    // Reset asserted in the middle of a read's ACCESS phase.
    wait_ready(0);
    drive(0, 1'b1, 1'b0, 16'h3000, 16'h0000);
    @(negedge Clk);
    drive(0, 1'b0, 1'b0, 16'h3000, 16'h0000);
    @(negedge Clk);
    chk_b("rst_mid_in_access", bus_a.Mem_CE_n, 1'b0);
    #2 Reset = 1'b0;
    #1;
    chk_b("rst_mid_ce_n",  bus_a.Mem_CE_n,    1'b1);
    chk_b("rst_mid_oe_n",  bus_a.Mem_OE_n,    1'b1);
    chk_b("rst_mid_we_n",  bus_a.Mem_WE_n,    1'b1);
    chk_b("rst_mid_doe",   bus_a.Mem_Data_OE, 1'b0);
    chk_b("rst_mid_ready", bus_a.Ready,       1'b1);
    chk_h("rst_mid_rdata", bus_a.Rdata,       16'h0000);
    chk_h("rst_mid_maddr", bus_a.Mem_Addr,    16'h0000);
    @(negedge Clk);
    #2 Reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (bus_a.Done) ndone++;
    end
    chk_i("rst_mid_no_done", ndone, 0);

    // Zero wait states: read then write.
    run_access(1, 1'b0, 16'h0010, 16'h0000, 2, 1, "w0_rd");
    chk_h("w0_rd_rdata", bus_b.Rdata, 16'h5A5A);
    run_access(1, 1'b1, 16'h0011, 16'hC3C3, 3, 1, "w0_wr");
    chk_h("w0_wr_sram", sram_b[16'h0011], 16'hC3C3);
    chk_h("w0_wr_rdata_kept", bus_b.Rdata, 16'h5A5A);

    repeat (3) @(negedge Clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
